// File: rtl/pipe_pkg.sv
// Shared pipeline definitions for the execute stage.
// Contents: ALUOp and funct7/funct3 encodings, the internal ALU-control,
// forwarding-select and multiplier-state enums, and the decode and
// forwarding-select helper functions.
package pipe_pkg;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE = 2'b11;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_SRA = 3'b101;
  localparam logic [2:0] F3_AND = 3'b111;

  typedef enum logic [2:0] {
    ALU_NONE, ALU_ADD, ALU_SUB, ALU_AND, ALU_XOR, ALU_SLL, ALU_SRA, ALU_MUL
  } alu_ctrl_e;

  typedef enum logic [1:0] {FWD_ID, FWD_MEM, FWD_WB} fwd_sel_e;

  typedef enum logic [1:0] {MUL_IDLE, MUL_BUSY, MUL_DONE} mul_state_e;

  // Unrecognised encodings decode to ALU_NONE, which yields a zero result.
  function automatic alu_ctrl_e alu_decode(input logic [1:0] alu_op,
                                           input logic [6:0] f7,
                                           input logic [2:0] f3);
    alu_ctrl_e ctrl;
    ctrl = ALU_NONE;
    case (alu_op)
      ALUOP_ADD: ctrl = ALU_ADD;
      ALUOP_SUB: ctrl = ALU_SUB;
      ALUOP_RTYPE: begin
        case ({f7, f3})
          {F7_BASE, F3_AND}:   ctrl = ALU_AND;
          {F7_BASE, F3_XOR}:   ctrl = ALU_XOR;
          {F7_BASE, F3_SLL}:   ctrl = ALU_SLL;
          {F7_BASE, F3_ADD}:   ctrl = ALU_ADD;
          {F7_ALT, F3_ADD}:    ctrl = ALU_SUB;
          {F7_MULDIV, F3_ADD}: ctrl = ALU_MUL;
          default:             ctrl = ALU_NONE;
        endcase
      end
      ALUOP_ITYPE: begin
        if (f3 == F3_ADD) ctrl = ALU_ADD;
        else if (f3 == F3_SRA && f7 == F7_ALT) ctrl = ALU_SRA;
      end
      default: ctrl = ALU_NONE;
    endcase
    return ctrl;
  endfunction

  // EX/MEM has priority over WB; x0 is never forwarded.
  function automatic fwd_sel_e fwd_select(input logic       mem_we,
                                          input logic [4:0] mem_rd,
                                          input logic       wb_we,
                                          input logic [4:0] wb_rd,
                                          input logic [4:0] src);
    if (mem_we && mem_rd != 5'd0 && mem_rd == src) return FWD_MEM;
    if (wb_we && wb_rd != 5'd0 && wb_rd == src) return FWD_WB;
    return FWD_ID;
  endfunction

endpackage

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier (low 32 bits of the product).
// Ports: clk_i/rst_i clock and synchronous active-high reset; start_i
// accepted only when idle, capturing a_i (multiplicand) and b_i
// (multiplier); busy_o high for ITERS cycles; done_o high for one cycle
// with product_o valid.
module mul_iter
  import pipe_pkg::*;
#(
  parameter int unsigned BITS  = 1,
  parameter int unsigned ITERS = 32 / BITS
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] product_o
);

  localparam int unsigned CNT_W = $clog2(ITERS);

  mul_state_e       state, state_nx;
  logic [31:0]      acc, mcand, mplier, partial;
  logic [CNT_W-1:0] cnt;
  logic             last_iter;

  assign last_iter = (cnt == CNT_W'(ITERS - 1));

  always_comb begin
    state_nx = state;
    case (state)
      MUL_IDLE: if (start_i) state_nx = MUL_BUSY;
      MUL_BUSY: if (last_iter) state_nx = MUL_DONE;
      MUL_DONE: state_nx = MUL_IDLE;
      default:  state_nx = MUL_IDLE;
    endcase
  end

  // Sum of the multiplicand shifted by each set bit of the low multiplier digit.
  always_comb begin
    partial = '0;
    for (int unsigned i = 0; i < BITS; i++) begin
      if (mplier[i]) partial = partial + (mcand << i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= MUL_IDLE;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else begin
      state <= state_nx;
      case (state)
        MUL_IDLE: begin
          if (start_i) begin
            acc    <= '0;
            mcand  <= a_i;
            mplier <= b_i;
            cnt    <= '0;
          end
        end
        MUL_BUSY: begin
          acc    <= acc + partial;
          mcand  <= mcand << BITS;
          mplier <= mplier >> BITS;
          cnt    <= cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign busy_o    = (state == MUL_BUSY);
  assign done_o    = (state == MUL_DONE);
  assign product_o = acc;

endmodule

// File: rtl/ex_stage.sv
// Execute stage of the 5-stage RISC-V pipeline.
// Inputs: ID/EX control, operands, funct fields and register addresses,
// plus EX/MEM and WB write-back info for forwarding.
// Outputs: stall_o (hold request while a MUL is in flight) and the EX/MEM
// pipeline register (controls, ALU/MUL result, store data, rd).
module ex_stage
  import pipe_pkg::*;
#(
  parameter int unsigned MUL_BITS_PER_CYCLE = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        RegWrite_i,
  input  logic        MemtoReg_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [1:0]  ALUOp_i,
  input  logic        ALUSrc_i,
  input  logic [31:0] RS1data_i,
  input  logic [31:0] RS2data_i,
  input  logic [31:0] immediate_i,
  input  logic [6:0]  funct7_i,
  input  logic [2:0]  funct3_i,
  input  logic [4:0]  RS1addr_i,
  input  logic [4:0]  RS2addr_i,
  input  logic [4:0]  RDaddr_i,
  input  logic        MEM_RegWrite_i,
  input  logic [4:0]  MEM_RDaddr_i,
  input  logic [31:0] MEM_ALUresult_i,
  input  logic        WB_RegWrite_i,
  input  logic [4:0]  WB_RDaddr_i,
  input  logic [31:0] WB_data_i,
  output logic        stall_o,
  output logic        RegWrite_o,
  output logic        MemtoReg_o,
  output logic        MemRead_o,
  output logic        MemWrite_o,
  output logic [31:0] ALUresult_o,
  output logic [31:0] MemData_o,
  output logic [4:0]  RDaddr_o
);

  localparam int unsigned MUL_ITERS = 32 / MUL_BITS_PER_CYCLE;

  fwd_sel_e    fwd_a, fwd_b;
  alu_ctrl_e   alu_ctrl;
  logic [31:0] op_a, rs2_fwd, op_b, alu_res, mul_product;
  logic        mul_busy, mul_done, mul_start;
  logic [3:0]  hold_ctl;
  logic [4:0]  hold_rd;

  always_comb begin
    fwd_a = fwd_select(MEM_RegWrite_i, MEM_RDaddr_i, WB_RegWrite_i, WB_RDaddr_i, RS1addr_i);
    fwd_b = fwd_select(MEM_RegWrite_i, MEM_RDaddr_i, WB_RegWrite_i, WB_RDaddr_i, RS2addr_i);
    case (fwd_a)
      FWD_MEM: op_a = MEM_ALUresult_i;
      FWD_WB:  op_a = WB_data_i;
      default: op_a = RS1data_i;
    endcase
    case (fwd_b)
      FWD_MEM: rs2_fwd = MEM_ALUresult_i;
      FWD_WB:  rs2_fwd = WB_data_i;
      default: rs2_fwd = RS2data_i;
    endcase
    op_b     = ALUSrc_i ? immediate_i : rs2_fwd;
    alu_ctrl = alu_decode(ALUOp_i, funct7_i, funct3_i);
  end

  always_comb begin
    alu_res = '0;
    case (alu_ctrl)
      ALU_ADD: alu_res = op_a + op_b;
      ALU_SUB: alu_res = op_a - op_b;
      ALU_AND: alu_res = op_a & op_b;
      ALU_XOR: alu_res = op_a ^ op_b;
      ALU_SLL: alu_res = op_a << op_b[4:0];
      ALU_SRA: alu_res = $signed(op_a) >>> immediate_i[4:0];
      default: alu_res = '0;  // ALU_NONE; MUL results come from mul_iter
    endcase
  end

  // While DONE the ID/EX register still holds the finished MUL, so a new
  // start is only recognised from IDLE.
  assign mul_start = (alu_ctrl == ALU_MUL) && !mul_busy && !mul_done;
  assign stall_o   = mul_start || mul_busy;

  mul_iter #(
    .BITS  (MUL_BITS_PER_CYCLE),
    .ITERS (MUL_ITERS)
  ) u_mul_iter (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .start_i   (mul_start),
    .a_i       (op_a),
    .b_i       (op_b),
    .busy_o    (mul_busy),
    .done_o    (mul_done),
    .product_o (mul_product)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hold_ctl <= '0;
      hold_rd  <= '0;
    end else if (mul_start) begin
      hold_ctl <= {RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i};
      hold_rd  <= RDaddr_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || (stall_o && !mul_done)) begin
      {RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o} <= '0;
      ALUresult_o <= '0;
      MemData_o   <= '0;
      RDaddr_o    <= '0;
    end else if (mul_done) begin
      {RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o} <= hold_ctl;
      ALUresult_o <= mul_product;
      MemData_o   <= '0;
      RDaddr_o    <= hold_rd;
    end else begin
      {RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o} <=
        {RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i};
      ALUresult_o <= alu_res;
      MemData_o   <= rs2_fwd;
      RDaddr_o    <= RDaddr_i;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: a driver applies stimulus on the falling
// edge and pushes the expected stall/EX-MEM view from a reference model;
// a monitor pops and compares shortly after each falling edge.
module tb_ex_stage;

  localparam int unsigned BPC   = 1;
  localparam int unsigned ITERS = 32 / BPC;

  localparam int OP_NONE = 0, OP_ADD = 1, OP_SUB = 2, OP_AND = 3,
                 OP_XOR = 4, OP_SLL = 5, OP_SRA = 6, OP_MUL = 7;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWrite, MemtoReg, MemRead, MemWrite;
  logic [1:0]  ALUOp;
  logic        ALUSrc;
  logic [31:0] RS1data, RS2data, immediate;
  logic [6:0]  funct7;
  logic [2:0]  funct3;
  logic [4:0]  RS1addr, RS2addr, RDaddr;
  logic        MEM_RegWrite;
  logic [4:0]  MEM_RDaddr;
  logic [31:0] MEM_ALUresult;
  logic        WB_RegWrite;
  logic [4:0]  WB_RDaddr;
  logic [31:0] WB_data;
  logic        stall_o, RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o;
  logic [31:0] ALUresult_o, MemData_o;
  logic [4:0]  RDaddr_o;

  ex_stage #(.MUL_BITS_PER_CYCLE(BPC)) dut (
    .clk_i(clk), .rst_i(rst),
    .RegWrite_i(RegWrite), .MemtoReg_i(MemtoReg), .MemRead_i(MemRead), .MemWrite_i(MemWrite),
    .ALUOp_i(ALUOp), .ALUSrc_i(ALUSrc),
    .RS1data_i(RS1data), .RS2data_i(RS2data), .immediate_i(immediate),
    .funct7_i(funct7), .funct3_i(funct3),
    .RS1addr_i(RS1addr), .RS2addr_i(RS2addr), .RDaddr_i(RDaddr),
    .MEM_RegWrite_i(MEM_RegWrite), .MEM_RDaddr_i(MEM_RDaddr), .MEM_ALUresult_i(MEM_ALUresult),
    .WB_RegWrite_i(WB_RegWrite), .WB_RDaddr_i(WB_RDaddr), .WB_data_i(WB_data),
    .stall_o(stall_o),
    .RegWrite_o(RegWrite_o), .MemtoReg_o(MemtoReg_o), .MemRead_o(MemRead_o), .MemWrite_o(MemWrite_o),
    .ALUresult_o(ALUresult_o), .MemData_o(MemData_o), .RDaddr_o(RDaddr_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  ctl;  // {RegWrite, MemtoReg, MemRead, MemWrite}
    logic [31:0] res;
    logic [31:0] md;
    logic [4:0]  rd;
  } exmem_t;

  typedef struct {
    bit     chk;
    logic   stall;
    exmem_t o;
  } item_t;

  item_t  sb[$];
  int     compared = 0;
  int     mismatched = 0;

  // Reference model state: phase 0 = free, 1..ITERS = multiplying, ITERS+1 = result due.
  int          m_phase = 0;
  bit          known = 0;
  exmem_t      cur = '0;
  logic [31:0] m_prod;
  logic [3:0]  m_ctl;
  logic [4:0]  m_rd;

  function automatic int mdl_op(input logic [1:0] op, input logic [6:0] f7, input logic [2:0] f3);
    if (op == 2'b00) return OP_ADD;
    if (op == 2'b01) return OP_SUB;
    if (op == 2'b11) begin
      if (f3 == 3'd0) return OP_ADD;
      if (f3 == 3'd5 && f7 == 7'h20) return OP_SRA;
      return OP_NONE;
    end
    if (f7 == 7'h01 && f3 == 3'd0) return OP_MUL;
    if (f7 == 7'h20 && f3 == 3'd0) return OP_SUB;
    if (f7 != 7'h00) return OP_NONE;
    case (f3)
      3'd7:    return OP_AND;
      3'd4:    return OP_XOR;
      3'd1:    return OP_SLL;
      3'd0:    return OP_ADD;
      default: return OP_NONE;
    endcase
  endfunction

  function automatic logic [31:0] pick(input logic [4:0] src, input logic [31:0] id_val);
    if (MEM_RegWrite && MEM_RDaddr != 0 && MEM_RDaddr == src) return MEM_ALUresult;
    if (WB_RegWrite && WB_RDaddr != 0 && WB_RDaddr == src) return WB_data;
    return id_val;
  endfunction

  task automatic step();
    item_t       it;
    int          op;
    logic [31:0] a, rs2f, b, r;
    exmem_t      nx;
    op       = mdl_op(ALUOp, funct7, funct3);
    it.chk   = known;
    it.o     = cur;
    it.stall = (m_phase == 0 && op == OP_MUL) || (m_phase >= 1 && m_phase <= ITERS);
    sb.push_back(it);
    a    = pick(RS1addr, RS1data);
    rs2f = pick(RS2addr, RS2data);
    b    = ALUSrc ? immediate : rs2f;
    nx   = '0;
    if (rst) begin
      m_phase = 0;
      known   = 1;
    end else if (m_phase == 0) begin
      if (op == OP_MUL) begin
        m_prod  = a * b;
        m_ctl   = {RegWrite, MemtoReg, MemRead, MemWrite};
        m_rd    = RDaddr;
        m_phase = 1;
      end else begin
        case (op)
          OP_ADD:  r = a + b;
          OP_SUB:  r = a - b;
          OP_AND:  r = a & b;
          OP_XOR:  r = a ^ b;
          OP_SLL:  r = a << b[4:0];
          OP_SRA:  r = $signed(a) >>> immediate[4:0];
          default: r = 32'd0;
        endcase
        nx = '{ctl: {RegWrite, MemtoReg, MemRead, MemWrite}, res: r, md: rs2f, rd: RDaddr};
      end
    end else if (m_phase <= ITERS) begin
      m_phase++;
    end else begin
      nx      = '{ctl: m_ctl, res: m_prod, md: 32'd0, rd: m_rd};
      m_phase = 0;
    end
    cur = nx;
  endtask

  task automatic tick();
    step();
    @(negedge clk);
  endtask

  task automatic set_ins(input logic [3:0] ctl, input logic [1:0] op, input logic [6:0] f7,
                         input logic [2:0] f3, input logic src, input logic [31:0] d1,
                         input logic [31:0] d2, input logic [31:0] im, input logic [4:0] a1,
                         input logic [4:0] a2, input logic [4:0] rd);
    {RegWrite, MemtoReg, MemRead, MemWrite} = ctl;
    ALUOp = op; funct7 = f7; funct3 = f3; ALUSrc = src;
    RS1data = d1; RS2data = d2; immediate = im;
    RS1addr = a1; RS2addr = a2; RDaddr = rd;
  endtask

  task automatic clr_fwd();
    MEM_RegWrite = 0; MEM_RDaddr = 0; MEM_ALUresult = 0;
    WB_RegWrite = 0; WB_RDaddr = 0; WB_data = 0;
  endtask

  task automatic rand_fwd();
    MEM_RegWrite = 1'($urandom); MEM_RDaddr = 5'($urandom_range(0, 7)); MEM_ALUresult = $urandom;
    WB_RegWrite = 1'($urandom); WB_RDaddr = 5'($urandom_range(0, 7)); WB_data = $urandom;
  endtask

  task automatic rand_ins();
    logic [6:0] f7;
    logic [2:0] f3;
    case ($urandom_range(0, 9))
      0: begin f7 = 7'h00; f3 = 3'd7; end
      1: begin f7 = 7'h00; f3 = 3'd4; end
      2: begin f7 = 7'h00; f3 = 3'd1; end
      3: begin f7 = 7'h00; f3 = 3'd0; end
      4: begin f7 = 7'h20; f3 = 3'd0; end
      5: begin f7 = 7'h01; f3 = 3'd0; end
      6: begin f7 = 7'h20; f3 = 3'd5; end
      default: begin f7 = 7'($urandom); f3 = 3'($urandom); end
    endcase
    set_ins(4'($urandom), 2'($urandom), f7, f3, 1'($urandom), $urandom, $urandom, $urandom,
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom));
    if (ALUOp == 2'b10) ALUSrc = 0;
  endtask

  task automatic nop();
    set_ins(4'b0000, 2'b00, 7'h00, 3'd0, 1'b0, 0, 0, 0, 0, 0, 0);
  endtask

  // Holds the MUL in ID/EX for its whole EX occupancy, as the hazard unit would.
  task automatic hold_mul(input bit drain);
    tick();
    for (int unsigned i = 0; i < ITERS + 1; i++) begin
      if (drain) rand_fwd();
      tick();
    end
  endtask

  initial begin : monitor
    item_t  it;
    exmem_t got;
    forever begin
      @(negedge clk);
      #3;
      if (sb.size() > 0) begin
        it = sb.pop_front();
        if (it.chk) begin
          got = '{ctl: {RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o}, res: ALUresult_o,
                  md: MemData_o, rd: RDaddr_o};
          compared++;
          if (stall_o !== it.stall) begin
            mismatched++;
            $display("FAIL stall @%0t: got %b expected %b", $time, stall_o, it.stall);
          end
          compared++;
          if (got !== it.o) begin
            mismatched++;
            $display("FAIL exmem @%0t: got ctl=%b res=%h md=%h rd=%0d expected ctl=%b res=%h md=%h rd=%0d",
                     $time, got.ctl, got.res, got.md, got.rd, it.o.ctl, it.o.res, it.o.md, it.o.rd);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : driver
    @(negedge clk);
    rst = 1;
    repeat (2) begin
      rand_ins();
      if (mdl_op(ALUOp, funct7, funct3) == OP_MUL) funct7 = 7'h00;
      rand_fwd();
      tick();
    end
    rst = 0;
    nop(); clr_fwd();
    repeat (2) tick();

    set_ins(4'b1000, 2'b10, 7'h00, 3'd0, 0, 5, 7, 0, 1, 2, 4);  tick();            // add 5+7
    set_ins(4'b0000, 2'b01, 7'h00, 3'd0, 0, 3, 5, 0, 1, 2, 0);  tick();            // sub 3-5
    set_ins(4'b1000, 2'b11, 7'h20, 3'd5, 1, 32'h8000_0000, 0, 32'h404, 1, 0, 5); tick(); // srai 4

    set_ins(4'b1000, 2'b11, 7'h00, 3'd0, 1, 32'hAAAA, 0, 1, 3, 0, 7);              // addi x3+1
    MEM_RegWrite = 1; MEM_RDaddr = 3; MEM_ALUresult = 32'h10;
    WB_RegWrite = 1;  WB_RDaddr = 3;  WB_data = 32'h20;
    tick();
    MEM_RDaddr = 0;
    tick();
    clr_fwd();

    set_ins(4'b1000, 2'b10, 7'h01, 3'd0, 0, 32'h0001_0001, 32'h0001_0000, 0, 1, 2, 8);
    hold_mul(1);
    clr_fwd();
    set_ins(4'b1000, 2'b10, 7'h01, 3'd0, 0, 7, 32'hFFFF_FFFD, 0, 1, 2, 9);
    hold_mul(1);
    clr_fwd();

    // Reset during BUSY cycle 10.
    set_ins(4'b1000, 2'b10, 7'h01, 3'd0, 0, 3, 4, 0, 1, 2, 10);
    repeat (10) tick();
    rst = 1; tick();
    rst = 0;
    set_ins(4'b1000, 2'b00, 7'h00, 3'd0, 0, 1, 1, 0, 1, 2, 11); tick();
    nop(); repeat (2) tick();

    // Back-to-back MULs, then an add consuming the second product via EX/MEM.
    set_ins(4'b1000, 2'b10, 7'h01, 3'd0, 0, 32'h1234, 32'h100, 0, 1, 2, 5);
    hold_mul(0);
    set_ins(4'b1000, 2'b10, 7'h01, 3'd0, 0, 32'hFFFF, 32'h1_0001, 0, 3, 4, 6);
    hold_mul(0);
    set_ins(4'b1000, 2'b10, 7'h00, 3'd0, 0, 0, 1, 0, 6, 7, 12);
    MEM_RegWrite = cur.ctl[3]; MEM_RDaddr = cur.rd; MEM_ALUresult = cur.res;
    tick();
    clr_fwd(); nop(); tick();

    repeat (300) begin
      rand_ins();
      rand_fwd();
      rst = ($urandom_range(0, 49) == 0);
      if (!rst && mdl_op(ALUOp, funct7, funct3) == OP_MUL) hold_mul(1);
      else tick();
      rst = 0;
    end
    nop(); clr_fwd();
    repeat (3) tick();

    @(negedge clk);
    #5;
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
